// File: rtl/sb_pkg.sv
// Shared sideband definitions: message width, inter-message gap length and
// receiver state encoding.
package sb_pkg;

    localparam int SB_MSG_W  = 64;
    localparam int SB_GAP_UI = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } sb_rx_state_t;

endpackage

// File: rtl/sb_rx_fifo.sv
// Message FIFO for the sideband receiver. A push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sb_rx_fifo
    import sb_pkg::*;
#(
    parameter int buffer_size = 4
) (
    input  logic                clk_800MHz,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic [SB_MSG_W-1:0] wdata,
    output logic [SB_MSG_W-1:0] rdata,
    output logic                full,
    output logic                empty
);

    localparam int AW = (buffer_size > 1) ? $clog2(buffer_size) : 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   DEPTH   = (AW+1)'(buffer_size);

    logic [SB_MSG_W-1:0] mem [buffer_size];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic                do_push;
    logic                do_pop;

    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_800MHz) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk_800MHz) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sb_rx_deserializer.sv
// Sideband receiver: assembles 64-bit LSB-first messages from strobed serial
// bits, enforces the inter-message gap and queues messages for the LTSM.
module sb_rx_deserializer
    import sb_pkg::*;
#(
    parameter int buffer_size = 4
) (
    input  logic                clk_800MHz,
    input  logic                reset,
    input  logic                enable_i,
    input  logic                clkPin_i,
    input  logic                dataPin_i,
    input  logic                msg_req_i,
    output logic [SB_MSG_W-1:0] data_o,
    output logic                valid_o,
    output logic                empty_o,
    output logic                full_o,
    output logic                overflow_o,
    output logic                frame_err_o,
    output logic [1:0]          state_o
);

    localparam logic [5:0] LAST_BIT = 6'(SB_MSG_W - 1);
    localparam logic [4:0] LAST_GAP = 5'(SB_GAP_UI - 1);

    sb_rx_state_t        state;
    logic [5:0]          bit_cnt;
    logic [4:0]          gap_cnt;
    logic                gap_err;
    logic [SB_MSG_W-1:0] shift_reg;
    logic                commit;
    logic [SB_MSG_W-1:0] fifo_rdata;
    logic                pop_ok;
    logic                drop;

    assign state_o = state;
    assign pop_ok  = msg_req_i & ~empty_o;
    assign drop    = commit & full_o & ~msg_req_i;

    // shift_reg holds the finished message during the commit cycle, since
    // nothing shifts once the FSM has left SHIFT.
    sb_rx_fifo #(.buffer_size(buffer_size)) u_fifo (
        .clk_800MHz (clk_800MHz),
        .reset      (reset),
        .push       (commit),
        .pop        (msg_req_i),
        .wdata      (shift_reg),
        .rdata      (fifo_rdata),
        .full       (full_o),
        .empty      (empty_o)
    );

    always_ff @(posedge clk_800MHz) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            gap_err     <= 1'b0;
            shift_reg   <= '0;
            commit      <= 1'b0;
            frame_err_o <= 1'b0;
            overflow_o  <= 1'b0;
            data_o      <= '0;
            valid_o     <= 1'b0;
        end else begin
            commit      <= 1'b0;
            frame_err_o <= 1'b0;
            valid_o     <= 1'b0;
            if (pop_ok) begin
                data_o  <= fifo_rdata;
                valid_o <= 1'b1;
            end
            if (drop) overflow_o <= 1'b1;

            if (!enable_i) begin
                state   <= IDLE;
                bit_cnt <= '0;
                gap_cnt <= '0;
                gap_err <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (clkPin_i) begin
                            shift_reg <= {dataPin_i, shift_reg[SB_MSG_W-1:1]};
                            bit_cnt   <= 6'd1;
                            state     <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (clkPin_i) begin
                            shift_reg <= {dataPin_i, shift_reg[SB_MSG_W-1:1]};
                            if (bit_cnt == LAST_BIT) begin
                                commit  <= 1'b1;
                                bit_cnt <= '0;
                                gap_cnt <= '0;
                                gap_err <= 1'b0;
                                state   <= GAP;
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end else begin
                            frame_err_o <= 1'b1;
                            bit_cnt     <= '0;
                            state       <= IDLE;
                        end
                    end
                    GAP: begin
                        // One error pulse per burst of early strobes; the low
                        // count restarts after the burst ends.
                        if (clkPin_i) begin
                            gap_cnt <= '0;
                            gap_err <= 1'b1;
                            if (!gap_err) frame_err_o <= 1'b1;
                        end else begin
                            gap_err <= 1'b0;
                            if (gap_cnt == LAST_GAP) begin
                                gap_cnt <= '0;
                                state   <= IDLE;
                            end else begin
                                gap_cnt <= gap_cnt + 5'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sb_rx_deserializer.sv
// Directed-sequence bench for sb_rx_deserializer with random message payloads
// and a message-level queue model of the receive FIFO.
module tb_sb_rx_deserializer;

    localparam int DEPTH = 4;

    logic        clk_800MHz = 1'b0;
    logic        reset      = 1'b1;
    logic        enable_i   = 1'b1;
    logic        clkPin_i   = 1'b0;
    logic        dataPin_i  = 1'b0;
    logic        msg_req_i  = 1'b0;
    logic [63:0] data_o;
    logic        valid_o;
    logic        empty_o;
    logic        full_o;
    logic        overflow_o;
    logic        frame_err_o;
    logic [1:0]  state_o;

    int vectors     = 0;
    int miscompares = 0;
    int fe_cnt      = 0;
    int fe_ref      = 0;

    logic [63:0] exp_q[$];
    logic        exp_ovf   = 1'b0;
    logic [63:0] last_data = '0;
    logic [63:0] m;

    sb_rx_deserializer #(.buffer_size(DEPTH)) dut (
        .clk_800MHz  (clk_800MHz),
        .reset       (reset),
        .enable_i    (enable_i),
        .clkPin_i    (clkPin_i),
        .dataPin_i   (dataPin_i),
        .msg_req_i   (msg_req_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .empty_o     (empty_o),
        .full_o      (full_o),
        .overflow_o  (overflow_o),
        .frame_err_o (frame_err_o),
        .state_o     (state_o)
    );

    always #5 clk_800MHz = ~clk_800MHz;

    always @(negedge clk_800MHz) begin
        if (frame_err_o === 1'b1) fe_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rand_msg();
        return {$urandom(), $urandom()};
    endfunction

    // Inputs change on the falling edge; the DUT samples them on the rising edge.
    task automatic drive_bit(input logic s, input logic d);
        clkPin_i  = s;
        dataPin_i = d;
        @(negedge clk_800MHz);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b0, 1'b0);
    endtask

    // gap = number of low cycles after the last strobe, including the commit cycle.
    task automatic send_msg(input logic [63:0] msg, input bit queued, input bit pop_at_commit,
                            input int gap);
        logic [63:0] e;
        for (int k = 0; k < 64; k++) drive_bit(1'b1, msg[k]);
        chk("empty_before_commit", empty_o, exp_q.size() == 0);
        if (pop_at_commit) msg_req_i = 1'b1;
        drive_bit(1'b0, 1'b0);
        msg_req_i = 1'b0;
        if (queued) begin
            if (pop_at_commit && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pop_at_commit_valid", valid_o, 1'b1);
                chk("pop_at_commit_data", data_o, e);
                last_data = e;
            end
            if (exp_q.size() < DEPTH) exp_q.push_back(msg);
            else exp_ovf = 1'b1;
        end
        chk("empty_after_commit", empty_o, exp_q.size() == 0);
        chk("full_after_commit", full_o, exp_q.size() == DEPTH);
        chk("overflow_after_commit", overflow_o, exp_ovf);
        idle_cycles(gap - 1);
    endtask

    task automatic pop_msg();
        logic [63:0] e;
        msg_req_i = 1'b1;
        drive_bit(1'b0, 1'b0);
        msg_req_i = 1'b0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pop_valid", valid_o, 1'b1);
            chk("pop_data", data_o, e);
            last_data = e;
        end else begin
            chk("pop_empty_valid", valid_o, 1'b0);
            chk("pop_empty_hold", data_o, last_data);
        end
        drive_bit(1'b0, 1'b0);
        chk("valid_one_cycle", valid_o, 1'b0);
        chk("pop_empty_flag", empty_o, exp_q.size() == 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"}, data_o, 64'd0);
        chk({tag, "_valid"}, valid_o, 1'b0);
        chk({tag, "_empty"}, empty_o, 1'b1);
        chk({tag, "_full"}, full_o, 1'b0);
        chk({tag, "_overflow"}, overflow_o, 1'b0);
        chk({tag, "_frame_err"}, frame_err_o, 1'b0);
        chk({tag, "_state"}, state_o, 2'd0);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        drive_bit(1'b0, 1'b0);
        reset = 1'b0;
        exp_q.delete();
        exp_ovf   = 1'b0;
        last_data = '0;
    endtask

    initial begin
        // Reset values
        @(negedge clk_800MHz);
        @(negedge clk_800MHz);
        check_reset_outputs("reset");
        reset = 1'b0;
        idle_cycles(2);

        // Single known message, then a pop, then a pop on the empty FIFO
        fe_ref = fe_cnt;
        send_msg(64'hA5A5_0000_1234_5678, 1'b1, 1'b0, 32);
        pop_msg();
        pop_msg();
        chk("no_frame_err_clean", fe_cnt, fe_ref);

        // Strobe dropped after 40 bits
        fe_ref = fe_cnt;
        m = rand_msg();
        for (int k = 0; k < 40; k++) drive_bit(1'b1, m[k]);
        idle_cycles(3);
        chk("drop40_frame_err", fe_cnt, fe_ref + 1);
        chk("drop40_empty", empty_o, 1'b1);
        send_msg(rand_msg(), 1'b1, 1'b0, 32);
        pop_msg();

        // Five messages without pops: fill then overflow
        for (int i = 0; i < 5; i++) send_msg(rand_msg(), 1'b1, 1'b0, 32);
        chk("ovf_full", full_o, 1'b1);
        chk("ovf_sticky", overflow_o, 1'b1);
        for (int i = 0; i < 5; i++) pop_msg();
        chk("ovf_stays_set", overflow_o, 1'b1);

        // Message strobed only 10 low cycles after the previous one
        fe_ref = fe_cnt;
        send_msg(rand_msg(), 1'b1, 1'b0, 10);
        send_msg(rand_msg(), 1'b0, 1'b0, 32);
        chk("short_gap_frame_err", fe_cnt, fe_ref + 1);
        pop_msg();
        pop_msg();

        // Commit and pop coincide while full
        reset_dut();
        for (int i = 0; i < 4; i++) send_msg(rand_msg(), 1'b1, 1'b0, 32);
        send_msg(rand_msg(), 1'b1, 1'b1, 32);
        chk("coincide_full", full_o, 1'b1);
        chk("coincide_no_ovf", overflow_o, 1'b0);
        for (int i = 0; i < 4; i++) pop_msg();

        // Enable drops mid-message: no error, FIFO kept, pops still serviced
        send_msg(rand_msg(), 1'b1, 1'b0, 32);
        fe_ref = fe_cnt;
        m = rand_msg();
        for (int k = 0; k < 20; k++) drive_bit(1'b1, m[k]);
        enable_i = 1'b0;
        drive_bit(1'b1, 1'b1);
        pop_msg();
        for (int i = 0; i < 3; i++) drive_bit(1'b1, $urandom_range(0, 1) != 0);
        chk("disable_state", state_o, 2'd0);
        enable_i = 1'b1;
        idle_cycles(1);
        chk("disable_no_frame_err", fe_cnt, fe_ref);
        send_msg(rand_msg(), 1'b1, 1'b0, 32);
        pop_msg();

        // Reset asserted at bit 30 with a message already queued
        send_msg(rand_msg(), 1'b1, 1'b0, 32);
        m = rand_msg();
        for (int k = 0; k < 30; k++) drive_bit(1'b1, m[k]);
        reset = 1'b1;
        drive_bit(1'b1, m[30]);
        check_reset_outputs("midmsg_reset");
        reset = 1'b0;
        exp_q.delete();
        exp_ovf   = 1'b0;
        last_data = '0;
        idle_cycles(2);
        send_msg(rand_msg(), 1'b1, 1'b0, 32);
        pop_msg();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sb_rx_deserializer.md
SB_RX_DESERIALIZER -- requirements
Module: sb_rx_deserializer

Interface
REQ-001 SHALL have parameter buffer_size, default 4, meaning FIFO depth in 64-bit messages (power of two, ≥2).
REQ-002 SHALL have port clk_800MHz, input, 1, sideband clock; the only clock.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port enable_i, input, 1, receiver enable.
REQ-005 SHALL have port clkPin_i, input, 1, forwarded-clock strobe; high = dataPin_i carries one valid bit this cycle.
REQ-006 SHALL have port dataPin_i, input, 1, serial sideband data.
REQ-007 SHALL have port msg_req_i, input, 1, pop request from the LTSM.
REQ-008 SHALL have port data_o, output, 64, popped message.
REQ-009 SHALL have port valid_o, output, 1, one-cycle pulse qualifying data_o.
REQ-010 SHALL have ports empty_o and full_o, output, 1 each, FIFO status.
REQ-011 SHALL have port overflow_o, output, 1, sticky flag for a message dropped because the FIFO was full.
REQ-012 SHALL have port frame_err_o, output, 1, one-cycle pulse on a framing violation.

Function
REQ-013 SHALL implement states IDLE, SHIFT and GAP.
REQ-014 SHALL sample one bit per cycle in which clkPin_i=1 and enable_i=1, LSB first: bit k of the message is the k-th sampled bit.
REQ-015 SHALL move IDLE->SHIFT on the first strobed bit and hold a 6-bit bit counter starting at 0.
REQ-016 SHALL, on the 64th strobed bit, commit the assembled message to the FIFO and enter GAP; empty_o SHALL fall on the following edge.
REQ-017 SHALL, if clkPin_i=0 in SHIFT before 64 bits, discard the partial message, pulse frame_err_o the next cycle and return to IDLE.
REQ-018 SHALL, in GAP, count consecutive clkPin_i=0 cycles and enter IDLE once the count reaches 32.
REQ-019 SHALL, if clkPin_i=1 in GAP before 32 low cycles (this includes a 65th consecutive strobe), pulse frame_err_o once, ignore those bits, and restart the gap count at the next low cycle.
REQ-020 SHALL, when a commit occurs with the FIFO full and no same-cycle pop, drop the message and set overflow_o; overflow_o SHALL clear only on reset.
REQ-021 SHALL, when a commit and a pop occur in the same cycle with the FIFO full, accept both and leave the occupancy unchanged.
REQ-022 SHALL, when msg_req_i=1 at an edge with the FIFO non-empty, drive the oldest entry on data_o and pulse valid_o at the next edge.
REQ-023 SHALL treat msg_req_i on an empty FIFO as a no-op: valid_o stays 0 and no error is raised.
REQ-024 SHALL hold data_o at its last popped value between pops.
REQ-025 SHALL, while enable_i=0, return to IDLE, discard any partial message and ignore pins, keep FIFO contents, and continue to service pops.
REQ-026 SHALL, when enable_i falls mid-SHIFT, not pulse frame_err_o.

Reset
REQ-027 SHALL, on reset, set state to IDLE, clear the counters, empty the FIFO, and drive data_o=0, valid_o=0, empty_o=1, full_o=0, overflow_o=0 and frame_err_o=0.
REQ-028 SHALL let reset asserted mid-message override all other activity and discard the partial message.

Structure
REQ-029 SHALL take SB_MSG_W=64, SB_GAP_UI=32 and the sb_rx_state_t enum from the shared package sb_pkg.
REQ-030 SHALL implement the FIFO as a sub-module sb_rx_fifo (push, pop, full, empty, buffer_size parameter).

Verification
REQ-031 SHALL cover: 64 strobes carrying 64'hA5A5_0000_1234_5678 LSB-first, then 32 low cycles, then a pop -> data_o=64'hA5A5_0000_1234_5678 with valid_o high for exactly 1 cycle, then empty_o=1.
REQ-032 SHALL cover: a strobe dropped after 40 bits -> frame_err_o pulses once, FIFO stays empty, and the next full message is received correctly.
REQ-033 SHALL cover: 5 messages with no pops and buffer_size=4 -> full_o=1 after the 4th, overflow_o=1 after the 5th, and 4 pops return messages 1-4 in order.
REQ-034 SHALL cover: a message strobed only 10 low cycles after the previous one -> frame_err_o pulses once and that message is not queued.
REQ-035 SHALL cover: the FIFO full while a commit and msg_req_i coincide -> the oldest entry is popped, the new entry is queued, and full_o stays 1.
REQ-036 SHALL cover: reset asserted at bit 30 -> all outputs at reset values the next cycle, and a subsequent message is received intact.
